// File: rtl/sense_led_pkg.sv
// Shared types and default sizing for the sense/LED timer.
// Channel FSM states use a 2-bit encoding.
package sense_led_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDelay = 2'd1,
    StOn    = 2'd2,
    StRearm = 2'd3
  } state_e;

  localparam int unsigned NchDefault        = 2;
  localparam int unsigned CntWDefault       = 8;
  localparam int unsigned SyncStagesDefault = 2;
  localparam int unsigned DebLenDefault     = 3;

endpackage

// File: rtl/sense_led_chan.sv
// One sense/LED channel: synchroniser, debouncer, delay/on-time FSM and sticky event flag.
// Define SENSE_LED_RETRIG_EN to let a new press during ON reload the on-time.
module sense_led_chan
  import sense_led_pkg::*;
#(
  parameter int unsigned CNT_W       = CntWDefault,
  parameter int unsigned SYNC_STAGES = SyncStagesDefault,
  parameter int unsigned DEB_LEN     = DebLenDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ena,
  input  logic             i_sense,
  input  logic [CNT_W-1:0] i_delay_cfg,
  input  logic [CNT_W-1:0] i_on_cfg,
  input  logic             i_clear,
  output logic             o_led,
  output logic             o_busy,
  output logic             o_event
);

  localparam int unsigned DebW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
  localparam logic [DebW-1:0]  DebLast = DebW'(DEB_LEN - 1);
  localparam logic [DebW-1:0]  DebOne  = DebW'(1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DebW-1:0]        r_deb_cnt;
  logic                   r_deb;
  logic                   r_deb_prev;
  state_e                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_on;
  logic                   r_led;
  logic                   r_event;

  logic w_sync;
  logic w_rise;
  logic w_set;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = r_deb & ~r_deb_prev;

  // Synchroniser and debouncer keep running regardless of i_ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= '0;
      r_deb_cnt  <= '0;
      r_deb      <= 1'b0;
      r_deb_prev <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], i_sense};
      r_deb_prev <= r_deb;
      if (w_sync != r_deb) begin
        if (r_deb_cnt == DebLast) begin
          r_deb     <= ~r_deb;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + DebOne;
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_set = i_ena & w_rise & (r_state == StIdle);
`ifdef SENSE_LED_RETRIG_EN
    if (i_ena && w_rise && (r_state == StOn) && (i_on_cfg != '0)) w_set = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_on    <= '0;
      r_led   <= 1'b0;
      r_event <= 1'b0;
    end else begin
      // Set beats clear when both land in the same cycle.
      if (w_set)        r_event <= 1'b1;
      else if (i_clear) r_event <= 1'b0;

      if (!i_ena) begin
        r_state <= StIdle;
        r_cnt   <= '0;
        r_led   <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_rise) begin
              r_on <= i_on_cfg;
              if (i_delay_cfg != '0) begin
                r_state <= StDelay;
                r_cnt   <= i_delay_cfg;
              end else if (i_on_cfg != '0) begin
                r_state <= StOn;
                r_cnt   <= i_on_cfg;
                r_led   <= 1'b1;
              end else begin
                r_state <= StRearm;
              end
            end
          end
          StDelay: begin
            if (r_cnt == CntOne) begin
              if (r_on != '0) begin
                r_state <= StOn;
                r_cnt   <= r_on;
                r_led   <= 1'b1;
              end else begin
                r_state <= StRearm;
                r_cnt   <= '0;
              end
            end else begin
              r_cnt <= r_cnt - CntOne;
            end
          end
          StOn: begin
`ifdef SENSE_LED_RETRIG_EN
            if (w_rise && (i_on_cfg != '0)) begin
              r_cnt <= i_on_cfg;
            end else
`endif
            if (r_cnt == CntOne) begin
              r_state <= StRearm;
              r_cnt   <= '0;
              r_led   <= 1'b0;
            end else begin
              r_cnt <= r_cnt - CntOne;
            end
          end
          StRearm: begin
            if (!r_deb) r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_led   = r_led;
  assign o_busy  = (r_state != StIdle);
  assign o_event = r_event;

endmodule

// File: rtl/sense_led_timer.sv
// Multi-channel sense/LED timer top: NCH independent channels sharing enable and config.
// Optional SENSE_LED_RETRIG_EN enables on-time extension on re-press (see sense_led_chan).
module sense_led_timer
  import sense_led_pkg::*;
#(
  parameter int unsigned NCH         = NchDefault,
  parameter int unsigned CNT_W       = CntWDefault,
  parameter int unsigned SYNC_STAGES = SyncStagesDefault,
  parameter int unsigned DEB_LEN     = DebLenDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [NCH-1:0]   sense_in,
  input  logic [CNT_W-1:0] delay_cfg,
  input  logic [CNT_W-1:0] on_cfg,
  input  logic [NCH-1:0]   clear,
  output logic [NCH-1:0]   led_out,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   event_latched
);

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    sense_led_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_LEN     (DEB_LEN)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_ena       (ena),
      .i_sense     (sense_in[g]),
      .i_delay_cfg (delay_cfg),
      .i_on_cfg    (on_cfg),
      .i_clear     (clear[g]),
      .o_led       (led_out[g]),
      .o_busy      (busy[g]),
      .o_event     (event_latched[g])
    );
  end

endmodule

// File: tb/tb_sense_led_timer.sv
// Directed self-checking bench for sense_led_timer (NCH=2, CNT_W=8, 2 sync stages, DEB_LEN=3).
// Input rise after edge 0 reaches the debounced level after edge 5; the FSM acts at edge 6.
module tb_sense_led_timer;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [1:0] sense_in;
  logic [7:0] delay_cfg;
  logic [7:0] on_cfg;
  logic [1:0] clear;
  logic [1:0] led_out;
  logic [1:0] busy;
  logic [1:0] event_latched;

  int n_vec;
  int n_err;

  sense_led_timer #(
    .NCH         (2),
    .CNT_W       (8),
    .SYNC_STAGES (2),
    .DEB_LEN     (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .sense_in      (sense_in),
    .delay_cfg     (delay_cfg),
    .on_cfg        (on_cfg),
    .clear         (clear),
    .led_out       (led_out),
    .busy          (busy),
    .event_latched (event_latched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ena      = 1'b1;
    sense_in = 2'b00;
    clear    = 2'b00;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (led_out !== 2'b00) begin
      n_err++; $display("FAIL reset led_out got %b exp 00", led_out);
    end
    n_vec++;
    if (busy !== 2'b00) begin
      n_err++; $display("FAIL reset busy got %b exp 00", busy);
    end
    n_vec++;
    if (event_latched !== 2'b00) begin
      n_err++; $display("FAIL reset event got %b exp 00", event_latched);
    end
  endtask

  task automatic test_basic_pulse();
    logic [1:0] e_led, e_busy;
    do_reset();
    delay_cfg = 8'd4;
    on_cfg    = 8'd5;
    sense_in  = 2'b01;
    for (int k = 1; k <= 18; k++) begin
      tick();
      e_led  = (k >= 10 && k <= 14) ? 2'b01 : 2'b00;
      e_busy = (k >= 6) ? 2'b01 : 2'b00;
      n_vec++;
      if (led_out !== e_led) begin
        n_err++; $display("FAIL basic led k=%0d got %b exp %b", k, led_out, e_led);
      end
      n_vec++;
      if (busy !== e_busy) begin
        n_err++; $display("FAIL basic busy k=%0d got %b exp %b", k, busy, e_busy);
      end
      n_vec++;
      if (event_latched !== e_busy) begin
        n_err++; $display("FAIL basic event k=%0d got %b exp %b", k, event_latched, e_busy);
      end
    end
  endtask

  task automatic test_bounce();
    int led_hi;
    do_reset();
    delay_cfg = 8'd1;
    on_cfg    = 8'd2;
    led_hi    = 0;
    for (int k = 0; k < 40; k++) begin
      sense_in = (k % 2 == 0) ? 2'b01 : 2'b00;
      tick();
      if (led_out != 2'b00 || busy != 2'b00) led_hi++;
    end
    sense_in = 2'b00;
    repeat (6) tick();
    n_vec++;
    if (led_hi !== 0) begin
      n_err++; $display("FAIL bounce active cycles got %0d exp 0", led_hi);
    end
    n_vec++;
    if (event_latched !== 2'b00) begin
      n_err++; $display("FAIL bounce event got %b exp 00", event_latched);
    end
  endtask

  task automatic test_zero_cfg();
    logic [1:0] e_led;
    do_reset();
    delay_cfg = 8'd0;
    on_cfg    = 8'd3;
    sense_in  = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      tick();
      e_led = (k >= 6 && k <= 8) ? 2'b01 : 2'b00;
      n_vec++;
      if (led_out !== e_led) begin
        n_err++; $display("FAIL zero_delay led k=%0d got %b exp %b", k, led_out, e_led);
      end
    end

    do_reset();
    delay_cfg = 8'd0;
    on_cfg    = 8'd0;
    sense_in  = 2'b01;
    repeat (16) tick();
    n_vec++;
    if ({led_out, busy, event_latched} !== 6'b00_01_01) begin
      n_err++; $display("FAIL zero_on led/busy/event got %b exp 000101",
                        {led_out, busy, event_latched});
    end
    sense_in = 2'b00;
    repeat (5) tick();
    n_vec++;
    if (busy !== 2'b01) begin
      n_err++; $display("FAIL zero_on rearm_hold busy got %b exp 01", busy);
    end
    tick();
    n_vec++;
    if (busy !== 2'b00) begin
      n_err++; $display("FAIL zero_on rearm_exit busy got %b exp 00", busy);
    end
  endtask

  task automatic test_hold();
    int hi, first;
    do_reset();
    delay_cfg = 8'd4;
    on_cfg    = 8'd5;
    sense_in  = 2'b01;
    hi        = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (led_out[0]) hi++;
    end
    n_vec++;
    if (hi !== 5) begin
      n_err++; $display("FAIL hold first_pulse_len got %0d exp 5", hi);
    end
    n_vec++;
    if (busy !== 2'b01) begin
      n_err++; $display("FAIL hold rearm busy got %b exp 01", busy);
    end
    sense_in = 2'b00;
    repeat (8) tick();
    n_vec++;
    if (busy !== 2'b00) begin
      n_err++; $display("FAIL hold release busy got %b exp 00", busy);
    end
    sense_in = 2'b01;
    hi       = 0;
    first    = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (led_out[0]) begin
        if (hi == 0) first = k;
        hi++;
      end
    end
    n_vec++;
    if (hi !== 5 || first !== 10) begin
      n_err++; $display("FAIL hold second_pulse len/start got %0d/%0d exp 5/10", hi, first);
    end
  endtask

  task automatic test_clear();
    logic [1:0] e_led;
    do_reset();
    delay_cfg = 8'd0;
    on_cfg    = 8'd1;
    sense_in  = 2'b01;
    repeat (7) tick();
    sense_in = 2'b00;
    repeat (6) tick();
    n_vec++;
    if ({busy[0], event_latched[0]} !== 2'b01) begin
      n_err++; $display("FAIL clear setup busy/event got %b exp 01", {busy[0], event_latched[0]});
    end
    sense_in = 2'b01;
    repeat (5) tick();
    clear = 2'b01;
    tick();
    clear = 2'b00;
    n_vec++;
    if ({led_out[0], event_latched[0]} !== 2'b11) begin
      n_err++; $display("FAIL clear set_wins led/event got %b exp 11",
                        {led_out[0], event_latched[0]});
    end
    sense_in = 2'b11;
    repeat (7) tick();
    n_vec++;
    if (event_latched !== 2'b11) begin
      n_err++; $display("FAIL clear ch1_set event got %b exp 11", event_latched);
    end
    clear = 2'b10;
    tick();
    clear = 2'b00;
    n_vec++;
    if (event_latched !== 2'b01) begin
      n_err++; $display("FAIL clear ch1_only event got %b exp 01", event_latched);
    end

    do_reset();
    delay_cfg = 8'd2;
    on_cfg    = 8'd3;
    sense_in  = 2'b11;
    for (int k = 1; k <= 12; k++) begin
      tick();
      e_led = (k >= 8 && k <= 10) ? 2'b11 : 2'b00;
      n_vec++;
      if (led_out !== e_led) begin
        n_err++; $display("FAIL both_ch led k=%0d got %b exp %b", k, led_out, e_led);
      end
    end
  endtask

  task automatic test_disrupt();
    int act;
    do_reset();
    delay_cfg = 8'd1;
    on_cfg    = 8'd8;
    sense_in  = 2'b01;
    repeat (8) tick();
    n_vec++;
    if (led_out !== 2'b01) begin
      n_err++; $display("FAIL ena_off pre led got %b exp 01", led_out);
    end
    ena = 1'b0;
    tick();
    n_vec++;
    if ({led_out, busy, event_latched} !== 6'b00_00_01) begin
      n_err++; $display("FAIL ena_off led/busy/event got %b exp 000001",
                        {led_out, busy, event_latched});
    end
    repeat (3) tick();
    ena = 1'b1;
    act = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (led_out != 2'b00 || busy != 2'b00) act++;
    end
    n_vec++;
    if (act !== 0) begin
      n_err++; $display("FAIL ena_reenable active cycles got %0d exp 0", act);
    end

    do_reset();
    delay_cfg = 8'd10;
    on_cfg    = 8'd2;
    sense_in  = 2'b01;
    repeat (8) tick();
    n_vec++;
    if ({busy, event_latched} !== 4'b01_01) begin
      n_err++; $display("FAIL mid_delay pre busy/event got %b exp 0101", {busy, event_latched});
    end
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({led_out, busy, event_latched} !== 6'b0) begin
      n_err++; $display("FAIL mid_delay reset outputs got %b exp 000000",
                        {led_out, busy, event_latched});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_repress_during_on();
    logic [1:0] e_led;
    int last;
    do_reset();
    delay_cfg = 8'd0;
    on_cfg    = 8'd20;
    sense_in  = 2'b01;
`ifdef SENSE_LED_RETRIG_EN
    last = 27;
`else
    last = 25;
`endif
    for (int k = 1; k <= 34; k++) begin
      tick();
      e_led = (k >= 6 && k <= last) ? 2'b01 : 2'b00;
      n_vec++;
      if (led_out !== e_led) begin
        n_err++; $display("FAIL repress led k=%0d got %b exp %b", k, led_out, e_led);
      end
      if (k == 7) sense_in = 2'b00;
      if (k == 12) begin
        sense_in = 2'b01;
        on_cfg   = 8'd10;
      end
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    ena       = 1'b1;
    sense_in  = 2'b00;
    clear     = 2'b00;
    delay_cfg = 8'd0;
    on_cfg    = 8'd0;
    test_reset();
    test_basic_pulse();
    test_bounce();
    test_zero_cfg();
    test_hold();
    test_clear();
    test_disrupt();
    test_repress_during_on();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sense_led_timer.md
Name: sense_led_timer

Overview:
- Parametrised digital controller for the analog sense/LED front end (VCR, latch, comparator, delay and timing cells).
- Takes NCH comparator outputs, synchronises and debounces them, and latches each trigger as a sticky event.
- Per channel, drives an LED-enable pulse after a programmable delay, for a programmable on-time.
- Replaces the single-channel analog latch/delay/timing chain with a counted, multi-channel digital equivalent.

Parameters:
- NCH, 2, number of independent sense/LED channels (1..8).
- CNT_W, 8, width of the delay and on-time counters and their config inputs.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (>=2).
- DEB_LEN, 3, consecutive equal synchronised samples required to change the debounced level (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global enable; 0 forces all channels idle.
- sense_in  in  NCH  raw asynchronous comparator outputs.
- delay_cfg  in  CNT_W  cycles from trigger to LED on (shared by all channels).
- on_cfg  in  CNT_W  LED on-time in cycles (shared by all channels).
- clear  in  NCH  per-channel clear of event_latched (pulse).
- led_out  out  NCH  registered LED enable.
- busy  out  NCH  channel is not in IDLE.
- event_latched  out  NCH  sticky record that a trigger occurred.

Behaviour:
- Clock and reset: single clock domain on clk. Reset is rst_n, asynchronous assert and active-low.
- Reset values: all outputs 0, synchronisers 0, debounced levels 0, FSMs IDLE, counters 0.
- Synchroniser: a SYNC_STAGES flip-flop chain per channel on sense_in.
- Debounce, per channel:
  - Counter increments while the synchronised bit differs from the debounced level, and resets to 0 when they match.
  - When the count reaches DEB_LEN, the debounced level flips.
  - A clean pin rise therefore reaches the debounced level SYNC_STAGES+DEB_LEN cycles later.
- Trigger: rising edge of the debounced level. It is acted on only in IDLE with ena=1; in any other state it is ignored.
- FSM per channel:
  - IDLE: on trigger, capture delay_cfg/on_cfg into channel registers and set event_latched.
    - Captured delay != 0: go to DELAY, counter=delay.
    - Captured delay == 0 and captured on != 0: go to ON.
    - Captured delay == 0 and captured on == 0: go to REARM.
  - DELAY: decrement each cycle. On the cycle the counter is 1: go to ON if captured on != 0, else REARM. Delay d gives exactly d cycles in DELAY.
  - ON: led_out=1, counter=on and decrements. Leave after exactly on cycles of led_out=1, then go to REARM.
  - REARM: wait for debounced level=0, then go to IDLE. This gives one pulse per press.
- Config changes after capture do not affect a running sequence.
- busy=1 in DELAY, ON and REARM.
- event_latched: set on trigger, cleared by clear[i]. If set and clear occur in the same cycle, set wins. It holds its value while ena=0.
- ena=0: all FSMs go to IDLE on the next edge and led_out drops. Synchronisers and debouncers keep running, so no false trigger occurs on re-enable if the input is already high.
- Reset mid-sequence: immediate return to reset values.
- Channels are fully independent; simultaneous triggers on multiple channels are all served.

Optional Feature:
- Macro: SENSE_LED_RETRIG_EN.
- Defined:
  - A new debounced rising edge while in ON reloads the on-counter from on_cfg, extending the pulse.
  - In REARM a rising edge cannot occur; a REARM exit followed by a new edge behaves as a normal IDLE trigger.
- Undefined: triggers outside IDLE are ignored (base behaviour).

Decomposition:
- Package sense_led_pkg:
  - State enum (IDLE, DELAY, ON, REARM), 2-bit encoding.
  - Default constants for CNT_W, SYNC_STAGES and DEB_LEN.
- Sub-module sense_led_chan: one channel (synchroniser, debouncer, FSM, counter, event flag).
- The top generates NCH instances of sense_led_chan plus the ena/config fan-out.

Test Plan:
- Basic pulse. NCH=2, delay_cfg=4, on_cfg=5, clean rise on ch0 held high.
  - Trigger at pin-rise+5 cycles (2 sync + 3 debounce).
  - led_out[0] high for exactly 5 cycles, starting 4 cycles after trigger.
  - event_latched[0]=1; ch1 stays idle.
- Bounce rejection. Toggle sense_in[0] with a 1-cycle high every 2 cycles -> no trigger, led_out=0, event_latched=0.
- Zero configs.
  - delay_cfg=0, on_cfg=3 -> LED high 3 cycles starting the cycle after trigger.
  - on_cfg=0 -> no LED, but event_latched=1 and FSM waits in REARM until input low.
- Hold without retrigger. Input held high 100 cycles -> single pulse; a second pulse occurs only after the input falls, is debounced low, then rises again.
- Clear priority and independence.
  - clear[0] with a simultaneous new trigger on ch0 -> event_latched stays 1.
  - clear[1] alone -> ch1 flag drops the next cycle.
  - Both channels triggered in the same cycle -> identical overlapping pulses.
- Disruption. ena=0 during ON -> led_out drops next edge, busy=0. rst_n low mid-DELAY -> all outputs 0 immediately. With SENSE_LED_RETRIG_EN, a re-press during ON extends the pulse to on_cfg cycles after the new trigger.
